// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, constants and the round-robin search used by the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STAT_W   = 16;
  localparam int MAX_NREQ = 8;

  // First set bit of req strictly after 'last', wrapping modulo nreq; returns 'last' if none.
  function automatic logic [2:0] rr_next(input logic [MAX_NREQ-1:0] req,
                                         input logic [2:0]          last,
                                         input int unsigned         nreq);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_NREQ; i++) begin
      idx = ({29'd0, last} + i) % nreq;
      if (i <= nreq && !found && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side signal bundle of the write arbiter.
// Optional statistics outputs appear when FIFO_ARB_STATS_EN is defined.
interface fifo_arb_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] wdata_in;
  logic [NREQ-1:0]        ack;
  logic                   fifo_full;
  logic                   fifo_wr;
  logic [DATA_W-1:0]      fifo_wdata;
  logic                   busy;
  logic [OW-1:0]          owner;
`ifdef FIFO_ARB_STATS_EN
  logic [NREQ*STAT_W-1:0] word_cnt;
  logic [STAT_W-1:0]      stall_cnt;
`endif

  modport slave (
    input  req, wdata_in, fifo_full,
    output ack, fifo_wr, fifo_wdata, busy, owner
`ifdef FIFO_ARB_STATS_EN
    , output word_cnt, stall_cnt
`endif
  );

  modport master (
    output req, wdata_in, fifo_full,
    input  ack, fifo_wr, fifo_wdata, busy, owner
`ifdef FIFO_ARB_STATS_EN
    , input word_cnt, stall_cnt
`endif
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after i_start, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [OW-1:0]   i_start,
  output logic [OW-1:0]   o_pick,
  output logic            o_found
);

  logic [MAX_NREQ-1:0] w_req_pad;
  logic [2:0]          w_start;
  logic [2:0]          w_last;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_req_pad             = '0;
    w_req_pad[NREQ-1:0]   = i_req;
  end

  // rr_next searches after 'last', so step back one from the start index.
  assign w_start = 3'(i_start);
  assign w_last  = (w_start == 3'd0) ? 3'(NREQ - 1) : w_start - 3'd1;
  assign o_pick  = OW'(rr_next(w_req_pad, w_last, NREQ));
  assign o_found = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst scheduler sharing one FIFO write port among NREQ producers.
// Define FIFO_ARB_STATS_EN to add per-requester word counters and a stall counter.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic       clk,
  input logic       rst,
  fifo_arb_if.slave bus
);

  localparam int OW = $clog2(NREQ);

  arb_state_t    r_state, w_state_nxt;
  logic [OW-1:0] r_owner, r_last_owner;
  logic [3:0]    r_burst_cnt;
  logic [OW-1:0] w_start, w_pick;
  logic          w_found, w_owner_req, w_accept, w_exit;

  assign w_start = (r_last_owner == OW'(NREQ - 1)) ? '0 : r_last_owner + 1'b1;

  rr_picker #(.NREQ(NREQ), .OW(OW)) u_picker (
    .i_req   (bus.req),
    .i_start (w_start),
    .o_pick  (w_pick),
    .o_found (w_found)
  );

  // Acceptance looks only at fifo_full of this cycle, so a full FIFO never sees a write.
  assign w_owner_req = bus.req[r_owner];
  assign w_accept    = (r_state == GRANT) && w_owner_req && !bus.fifo_full;
  assign w_exit      = (r_state == GRANT) &&
                       ((w_accept && r_burst_cnt == 4'(MAX_BURST - 1)) || !w_owner_req);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = GRANT;
      GRANT:   if (w_exit)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= OW'(NREQ - 1);
      r_last_owner <= OW'(NREQ - 1);
      r_burst_cnt  <= '0;
    end else if (r_state == IDLE) begin
      if (w_found) begin
        r_owner     <= w_pick;
        r_burst_cnt <= '0;
      end
    end else begin
      if (w_accept) r_burst_cnt  <= r_burst_cnt + 1'b1;
      if (w_exit)   r_last_owner <= r_owner;
    end
  end

  always_comb begin
    bus.ack = '0;
    if (w_accept) bus.ack[r_owner] = 1'b1;
  end

  assign bus.fifo_wr    = w_accept;
  assign bus.fifo_wdata = bus.wdata_in[r_owner*DATA_W +: DATA_W];
  assign bus.busy       = (r_state == GRANT);
  assign bus.owner      = r_owner;

`ifdef FIFO_ARB_STATS_EN
  logic [NREQ-1:0][STAT_W-1:0] r_word_cnt;
  logic [STAT_W-1:0]           r_stall_cnt;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_accept && r_owner == OW'(i) && r_word_cnt[i] != '1)
          r_word_cnt[i] <= r_word_cnt[i] + 1'b1;
      end
      if (r_state == GRANT && w_owner_req && bus.fifo_full && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.word_cnt  = r_word_cnt;
  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
